// File: rtl/banked_ram_pkg.sv
// Shared definitions for the banked RAM: FSM state encoding and bank geometry.
package banked_ram_pkg;

  // Two-state fill engine: CLEAR owns the array, READY serves reads/writes.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Number of words held by each bank for a given total address width.
  function automatic int rows_per_bank(input int addr_w, input int bank_bits);
    return 32'sd1 << (addr_w - bank_bits);
  endfunction

endpackage

// File: rtl/banked_ram_bank.sv
// ram_bank: one bank of the banked RAM, synchronous write and combinational read.
module ram_bank #(
  parameter int WIDTH = 16,
  parameter int ROW_W = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ROW_W-1:0] row,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int ROWS = 1 << ROW_W;

  logic [WIDTH-1:0] mem_r [ROWS];

  // Storage update; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[row] <= wdata;
    end
  end

  assign rdata = mem_r[row];

endmodule

// File: rtl/banked_ram.sv
// banked_ram: power-of-two word array split into 2^BANK_BITS banks with a
// registered read port. Optional zero-fill engine enabled by the macro
// BANKED_RAM_CLEAR_EN; without it the array powers up undefined.
module banked_ram
  import banked_ram_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 9,
  parameter int BANK_BITS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int ROW_W  = ADDR_W - BANK_BITS;
  localparam int NBANKS = 1 << BANK_BITS;

  logic [ROW_W-1:0]  row_s;
  logic              fill_s;
  logic [ROW_W-1:0]  fill_row_s;
  logic [NBANKS-1:0] bank_en_s;
  logic [WIDTH-1:0]  rdata_s [NBANKS];
  logic [WIDTH-1:0]  rd_word_s;
  logic [WIDTH-1:0]  out_r;
  logic              busy_r;

  assign row_s = address[ROW_W-1:0];

  // Bank decode and read mux; a single bank degenerates to a constant enable.
  generate
    if (BANK_BITS > 0) begin : g_sel
      logic [BANK_BITS-1:0] bank_s;
      assign bank_s    = address[ADDR_W-1 -: BANK_BITS];
      assign rd_word_s = rdata_s[bank_s];
      for (genvar b = 0; b < NBANKS; b++) begin : g_dec
        assign bank_en_s[b] = (bank_s == BANK_BITS'(b));
      end
    end else begin : g_nosel
      assign bank_en_s = 1'b1;
      assign rd_word_s = rdata_s[0];
    end
  endgenerate

  // During a fill every bank writes zero at the fill row; otherwise only the
  // decoded bank writes the incoming word.
  generate
    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      logic             we_s;
      logic [ROW_W-1:0] bank_row_s;
      logic [WIDTH-1:0] bank_wdata_s;
      assign we_s         = fill_s | (load & bank_en_s[b]);
      assign bank_row_s   = fill_s ? fill_row_s : row_s;
      assign bank_wdata_s = fill_s ? {WIDTH{1'b0}} : in;
      ram_bank #(
        .WIDTH (WIDTH),
        .ROW_W (ROW_W)
      ) u_bank (
        .clk   (clk),
        .we    (we_s),
        .row   (bank_row_s),
        .wdata (bank_wdata_s),
        .rdata (rdata_s[b])
      );
    end
  endgenerate

`ifdef BANKED_RAM_CLEAR_EN
  localparam int               ROWS     = rows_per_bank(ADDR_W, BANK_BITS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t           state_r;
  logic [ROW_W-1:0] count_r;

  assign fill_s     = (state_r == ST_CLEAR);
  assign fill_row_s = count_r;

  // Fill-engine FSM with the row counter and registered out/busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_CLEAR;
      count_r <= {ROW_W{1'b0}};
      out_r   <= {WIDTH{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          out_r <= {WIDTH{1'b0}};
          if (count_r == LAST_ROW) begin
            state_r <= ST_READY;
            count_r <= {ROW_W{1'b0}};
            busy_r  <= 1'b0;
          end else begin
            count_r <= count_r + 1'b1;
            busy_r  <= 1'b1;
          end
        end
        ST_READY: begin
          out_r <= rd_word_s;
          if (clear) begin
            state_r <= ST_CLEAR;
            count_r <= {ROW_W{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_CLEAR;
          count_r <= {ROW_W{1'b0}};
          out_r   <= {WIDTH{1'b0}};
          busy_r  <= 1'b1;
        end
      endcase
    end
  end
`else
  logic unused_clear_s;

  assign fill_s         = 1'b0;
  assign fill_row_s     = {ROW_W{1'b0}};
  assign unused_clear_s = clear;

  // Permanently ready: only the read register is live, busy stays low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_r  <= {WIDTH{1'b0}};
      busy_r <= 1'b0;
    end else begin
      out_r  <= rd_word_s;
      busy_r <= 1'b0;
    end
  end
`endif

  assign out  = out_r;
  assign busy = busy_r;

endmodule
